// File: rtl/keypad_cmd_if.sv
// Command channel of the keypad emulator: one key press request per
// valid/ready transfer.
interface keypad_cmd_if #(
    parameter int HOLD_W = 24
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic              cmd_bounce;

    modport master (
        output cmd_valid, cmd_key, cmd_hold, cmd_bounce,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_key, cmd_hold, cmd_bounce,
        output cmd_ready
    );
endinterface

// File: rtl/keypad_emulator.sv
// Stands in for a physical 4x4 keypad: answers the scanner's active-low column
// drive on the commanded key's row, with optional contact bounce.
module keypad_emulator #(
    parameter int BOUNCE_PERIOD = 6000,
    parameter int BOUNCE_PULSES = 3,
    parameter int GAP_CYCLES    = 240000,
    parameter int HOLD_W        = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    keypad_cmd_if.slave cmd,
    output logic       busy,
    output logic       done,
    output logic       contact
);

    localparam int PHASE_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int IDX_W   = (BOUNCE_PULSES > 0) ? $clog2(2 * BOUNCE_PULSES) + 1 : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LOAD = PHASE_W'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]   LAST_PHASE = IDX_W'((BOUNCE_PULSES > 0) ? 2 * BOUNCE_PULSES - 1 : 0);
    localparam bit                 BOUNCE_EN  = (BOUNCE_PULSES > 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRESS_B = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_REL_B   = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [2:0]        state_reg,     state_next;
    logic [PHASE_W-1:0] phase_cnt_reg, phase_cnt_next;
    logic [IDX_W-1:0]  phase_idx_reg, phase_idx_next;
    logic [HOLD_W-1:0] hold_cnt_reg,  hold_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg,   gap_cnt_next;
    logic [3:0]        key_reg,       key_next;
    logic              bounce_reg,    bounce_next;
    logic              contact_reg,   contact_next;
    logic              done_reg,      done_next;
    logic [3:0]        col_meta_reg;
    logic [3:0]        col_s_reg;
    logic [3:0]        row_reg;
    logic [3:0]        row_hit;

    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        phase_idx_next = phase_idx_reg;
        hold_cnt_next  = hold_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        key_next       = key_reg;
        bounce_next    = bounce_reg;
        contact_next   = contact_reg;
        done_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    key_next      = cmd.cmd_key;
                    bounce_next   = cmd.cmd_bounce && BOUNCE_EN;
                    // A zero hold still closes the contact for one cycle.
                    hold_cnt_next = (cmd.cmd_hold == '0) ? '0 : cmd.cmd_hold - 1'b1;
                    contact_next  = 1'b1;
                    if (cmd.cmd_bounce && BOUNCE_EN) begin
                        state_next     = S_PRESS_B;
                        phase_cnt_next = PHASE_LOAD;
                        phase_idx_next = '0;
                    end else begin
                        state_next = S_HOLD;
                    end
                end
            end
            S_PRESS_B, S_REL_B: begin
                if (phase_cnt_reg != '0) begin
                    phase_cnt_next = phase_cnt_reg - 1'b1;
                end else if (phase_idx_reg == LAST_PHASE) begin
                    if (state_reg == S_PRESS_B) begin
                        state_next   = S_HOLD;
                        contact_next = 1'b1;
                    end else begin
                        state_next   = S_GAP;
                        gap_cnt_next = GAP_LOAD;
                        contact_next = 1'b0;
                    end
                end else begin
                    // Phases alternate, so each boundary simply flips the contact.
                    phase_idx_next = phase_idx_reg + 1'b1;
                    phase_cnt_next = PHASE_LOAD;
                    contact_next   = ~contact_reg;
                end
            end
            S_HOLD: begin
                if (hold_cnt_reg != '0) begin
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                end else begin
                    contact_next = 1'b0;
                    if (bounce_reg) begin
                        state_next     = S_REL_B;
                        phase_cnt_next = PHASE_LOAD;
                        phase_idx_next = '0;
                    end else begin
                        state_next   = S_GAP;
                        gap_cnt_next = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_reg != '0) begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end else begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next   = S_IDLE;
                contact_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            phase_cnt_reg <= '0;
            phase_idx_reg <= '0;
            hold_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            key_reg       <= '0;
            bounce_reg    <= 1'b0;
            contact_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            phase_idx_reg <= phase_idx_next;
            hold_cnt_reg  <= hold_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            key_reg       <= key_next;
            bounce_reg    <= bounce_next;
            contact_reg   <= contact_next;
            done_reg      <= done_next;
        end
    end

    // Column pins are asynchronous to clk; two flops before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_reg <= 4'hF;
            col_s_reg    <= 4'hF;
        end else begin
            col_meta_reg <= col;
            col_s_reg    <= col_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_hit[gi] = contact_reg && (key_reg[3:2] == 2'(gi)) && !col_s_reg[key_reg[1:0]];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_reg <= 4'hF;
        end else begin
            row_reg <= ~row_hit;
        end
    end

    assign row           = row_reg;
    assign cmd.cmd_ready = (state_reg == S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign done          = done_reg;
    assign contact       = contact_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator: a per-cycle contact plan built from the
// press/hold/release timing rules predicts row, contact, busy, done and ready.
module tb_keypad_emulator;

    localparam int HW  = 24;
    localparam int PER = 4;
    localparam int PUL = 2;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic       done;
    logic       contact;

    keypad_cmd_if #(.HOLD_W(HW)) cmd_bus ();

    keypad_emulator #(
        .BOUNCE_PERIOD(PER),
        .BOUNCE_PULSES(PUL),
        .GAP_CYCLES   (GAP),
        .HOLD_W       (HW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .col    (col),
        .row    (row),
        .cmd    (cmd_bus),
        .busy   (busy),
        .done   (done),
        .contact(contact)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit         plan[$];
    logic       m_busy = 1'b0;
    logic       m_contact = 1'b0;
    logic [3:0] m_key = 4'h0;
    logic [3:0] ch0 = 4'hF, ch1 = 4'hF, ch2 = 4'hF;
    logic [3:0] exp_row = 4'hF;
    logic       exp_done = 1'b0;
    logic       m_xfer = 1'b0;
    int         n_xfer = 0;
    logic [7:0] obs_vec, exp_vec;

    // Scanner model.
    bit scan_en = 1'b0;
    int scan_idx = 0, scan_dwell = 2, scan_cnt = 0;

    function automatic void build_plan(int hold, bit bounce);
        int h = (hold == 0) ? 1 : hold;
        if (bounce) for (int p = 0; p < 2 * PUL; p++) repeat (PER) plan.push_back(p % 2 == 0);
        repeat (h) plan.push_back(1'b1);
        if (bounce) for (int p = 0; p < 2 * PUL; p++) repeat (PER) plan.push_back(p % 2 == 1);
        repeat (GAP) plan.push_back(1'b0);
    endfunction

    task automatic drive(input logic [3:0] k, input int h, input logic b);
        cmd_bus.cmd_key    = k;
        cmd_bus.cmd_hold   = HW'(h);
        cmd_bus.cmd_bounce = b;
        cmd_bus.cmd_valid  = 1'b1;
    endtask

    // Advance one clock, update the model, sample the DUT 1 ns after the edge.
    task automatic tick();
        logic v, b, prev_busy, prev_contact;
        logic [3:0] k, c;
        int h;
        v = cmd_bus.cmd_valid; k = cmd_bus.cmd_key; h = int'(cmd_bus.cmd_hold);
        b = cmd_bus.cmd_bounce; c = col;
        @(posedge clk);
        #1;
        m_xfer = 1'b0;
        if (reset) begin
            plan.delete();
            m_busy = 1'b0; m_contact = 1'b0; exp_done = 1'b0; exp_row = 4'hF;
            ch0 = 4'hF; ch1 = 4'hF; ch2 = 4'hF;
        end else begin
            prev_busy = m_busy;
            prev_contact = m_contact;
            ch2 = ch1; ch1 = ch0; ch0 = c;
            for (int r = 0; r < 4; r++)
                exp_row[r] = ~(prev_contact && (int'(m_key[3:2]) == r) && !ch2[m_key[1:0]]);
            if (!prev_busy && v) begin
                m_key = k;
                build_plan(h, b);
                m_xfer = 1'b1;
                n_xfer++;
            end
            if (plan.size() > 0) begin
                m_contact = plan.pop_front();
                m_busy = 1'b1;
            end else begin
                m_contact = 1'b0;
                m_busy = 1'b0;
            end
            exp_done = prev_busy && !m_busy;
        end
        if (scan_en) begin
            scan_cnt++;
            if (scan_cnt >= scan_dwell) begin
                scan_cnt = 0;
                scan_idx = (scan_idx + 1) % 4;
                col = ~(4'b0001 << scan_idx);
            end
        end
        obs_vec = {row, contact, busy, done, cmd_bus.cmd_ready};
        exp_vec = {exp_row, m_contact, m_busy, exp_done, !m_busy};
        if (done) $display("txn key=%h complete at %0t", m_key, $time);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (row !== 4'hF) begin bad++; $display("FAIL reset_row got=%b want=1111", row); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (contact !== 1'b0) begin bad++; $display("FAIL reset_contact got=%b want=0", contact); end
        total++; if (cmd_bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_bus.cmd_ready); end
        tick(); tick();
        reset = 1'b0;
        tick();
        total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL reset_idle got=%b want=%b", obs_vec, exp_vec); end
    endtask

    task automatic test_no_bounce();
        int hi = 0, rlo = 0, rlo_exp = 0, odd = 0, dn = 0;
        bit fin = 0;
        drive(4'b0110, 20, 1'b0);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            tick();
            if (m_xfer) cmd_bus.cmd_valid = 1'b0;
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL nobounce_cyc%0d got=%b want=%b", cyc, obs_vec, exp_vec); end
            if (contact === 1'b1) hi++;
            if (done === 1'b1) dn++;
            if (row === 4'b1101) rlo++;
            if (row !== 4'hF && row !== 4'b1101) odd++;
            if (exp_row == 4'b1101) rlo_exp++;
            if (exp_done) fin = 1;
        end
        total++; if (hi !== 20) begin bad++; $display("FAIL nobounce_contact_cycles got=%0d want=20", hi); end
        total++; if (rlo !== rlo_exp) begin bad++; $display("FAIL nobounce_row_low_cycles got=%0d want=%0d", rlo, rlo_exp); end
        total++; if (odd !== 0) begin bad++; $display("FAIL nobounce_wrong_row got=%0d want=0", odd); end
        total++; if (dn !== 1) begin bad++; $display("FAIL nobounce_done_pulses got=%0d want=1", dn); end
    endtask

    task automatic test_bounce();
        int t0 = -1, tdone = -1, rises = 0;
        logic last_c = 1'b0;
        bit fin = 0;
        drive(4'b0110, 20, 1'b1);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            tick();
            if (m_xfer) begin cmd_bus.cmd_valid = 1'b0; t0 = cyc; end
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL bounce_cyc%0d got=%b want=%b", cyc, obs_vec, exp_vec); end
            if (contact === 1'b1 && last_c === 1'b0) rises++;
            last_c = contact;
            if (done === 1'b1 && tdone < 0) tdone = cyc;
            if (exp_done) fin = 1;
        end
        // Press bounce, hold, release bounce and gap, all in whole cycles.
        total++; if (tdone - t0 !== 2 * PUL * PER * 2 + 20 + GAP) begin bad++; $display("FAIL bounce_done_offset got=%0d want=%0d", tdone - t0, 2 * PUL * PER * 2 + 20 + GAP); end
        total++; if (rises !== 5) begin bad++; $display("FAIL bounce_closures got=%0d want=5", rises); end
    endtask

    task automatic test_hold_zero();
        int hi = 0, dn = 0;
        bit fin = 0;
        drive(4'($urandom_range(0, 15)), 0, 1'b0);
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            tick();
            if (m_xfer) cmd_bus.cmd_valid = 1'b0;
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL hold0_cyc%0d got=%b want=%b", cyc, obs_vec, exp_vec); end
            if (contact === 1'b1) hi++;
            if (done === 1'b1) dn++;
            if (exp_done) fin = 1;
        end
        total++; if (hi !== 1) begin bad++; $display("FAIL hold0_contact_cycles got=%0d want=1", hi); end
        total++; if (dn !== 1) begin bad++; $display("FAIL hold0_done_pulses got=%0d want=1", dn); end
    endtask

    task automatic test_back_to_back();
        int start_x = n_xfer, dn = 0, starts = 0, after_done = 0;
        logic last_b = 1'b0, prev_done = 1'b0;
        drive(4'($urandom_range(0, 15)), int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)));
        for (int cyc = 0; cyc < 400 && dn < 2; cyc++) begin
            tick();
            if (m_xfer && n_xfer - start_x == 2) cmd_bus.cmd_valid = 1'b0;
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL b2b_cyc%0d got=%b want=%b", cyc, obs_vec, exp_vec); end
            if (busy === 1'b1 && last_b === 1'b0) starts++;
            if (prev_done === 1'b1 && busy === 1'b1) after_done++;
            last_b = busy;
            prev_done = done;
            if (done === 1'b1) dn++;
        end
        total++; if (starts !== 2) begin bad++; $display("FAIL b2b_transfers got=%0d want=2", starts); end
        total++; if (after_done !== 1) begin bad++; $display("FAIL b2b_restart_after_done got=%0d want=1", after_done); end
        total++; if (dn !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", dn); end
    endtask

    task automatic test_reset_hold();
        int dn = 0, hi = 0;
        bit fin = 0;
        drive(4'b0110, 30, 1'b0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (m_xfer) cmd_bus.cmd_valid = 1'b0;
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rsthold_pre_cyc%0d got=%b want=%b", cyc, obs_vec, exp_vec); end
        end
        #2;
        reset = 1'b1;
        #1;
        total++; if (row !== 4'hF) begin bad++; $display("FAIL rsthold_row got=%b want=1111", row); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rsthold_busy got=%b want=0", busy); end
        total++; if (contact !== 1'b0) begin bad++; $display("FAIL rsthold_contact got=%b want=0", contact); end
        for (int cyc = 0; cyc < 2; cyc++) begin
            tick();
            if (done === 1'b1) dn++;
        end
        reset = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            if (done === 1'b1) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL rsthold_spurious_done got=%0d want=0", dn); end
        drive(4'b1001, 6, 1'b1);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            tick();
            if (m_xfer) cmd_bus.cmd_valid = 1'b0;
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rsthold_post_cyc%0d got=%b want=%b", cyc, obs_vec, exp_vec); end
            if (contact === 1'b1) hi++;
            if (exp_done) fin = 1;
        end
        total++; if (hi !== 6 + 2 * PUL * PER) begin bad++; $display("FAIL rsthold_post_contact got=%0d want=%0d", hi, 6 + 2 * PUL * PER); end
    endtask

    task automatic test_all_cols_low();
        bit fin = 0;
        int seen = 0, stage = 0;
        logic [3:0] want_lat [3];
        want_lat[0] = 4'b0111; want_lat[1] = 4'b0111; want_lat[2] = 4'hF;
        scan_en = 1'b0;
        col = 4'b0000;
        drive(4'b1111, 12, 1'b0);
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            tick();
            if (m_xfer) cmd_bus.cmd_valid = 1'b0;
            total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL allcols_cyc%0d got=%b want=%b", cyc, obs_vec, exp_vec); end
            if (stage >= 1 && stage <= 3) begin
                total++;
                if (row !== want_lat[stage-1]) begin bad++; $display("FAIL allcols_latency_%0d got=%b want=%b", stage, row, want_lat[stage-1]); end
                stage++;
            end
            if (contact === 1'b1) seen++;
            if (seen == 3 && stage == 0) begin col = 4'b1111; stage = 1; end
            if (exp_done) fin = 1;
        end
        total++; if (stage !== 4) begin bad++; $display("FAIL allcols_latency_reached got=%0d want=4", stage); end
        col = 4'hF;
        scan_en = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            bit fin = 0;
            scan_dwell = int'($urandom_range(1, 3));
            repeat ($urandom_range(0, 3)) begin
                tick();
                total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rand%0d_idle got=%b want=%b", n, obs_vec, exp_vec); end
            end
            drive(4'($urandom_range(0, 15)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
                tick();
                if (m_xfer) cmd_bus.cmd_valid = 1'b0;
                total++; if (obs_vec !== exp_vec) begin bad++; $display("FAIL rand%0d_cyc%0d got=%b want=%b", n, cyc, obs_vec, exp_vec); end
                if (exp_done) fin = 1;
            end
        end
    endtask

    initial begin
        col = 4'hF;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_key    = 4'h0;
        cmd_bus.cmd_hold   = '0;
        cmd_bus.cmd_bounce = 1'b0;
        test_reset();
        scan_en = 1'b1;
        scan_dwell = 2;
        test_no_bounce();
        test_bounce();
        test_hold_zero();
        test_back_to_back();
        test_reset_hold();
        test_all_cols_low();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
